alu_pipe: RTL and testbench

//  Parametrised pipelined integer ALU for the out-of-order core. It sits between the ALU

---
 rtl/alu_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Pipelined integer ALU between the ALU reservation station and the CDB arbiter.
// Ops flow through STAGES-1 register stages into an output FIFO; the RS is
// throttled by an occupancy count that reserves a FIFO slot for every accepted op.
module alu_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ROB_W      = 5,
  parameter int unsigned OP_W       = 4,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned OBUF_DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             _clear,
  input  logic             _alu_ready,
  input  logic [ROB_W-1:0] _alu_rob_id,
  input  logic [OP_W-1:0]  _alu_op,
  input  logic [XLEN-1:0]  _alu_v1,
  input  logic [XLEN-1:0]  _alu_v2,
  output logic             _alu_full,
  input  logic             _cdb_grant,
  output logic             _cdb_ready,
  output logic [ROB_W-1:0] _cdb_rob_id,
  output logic [XLEN-1:0]  _cdb_value
);

  localparam int unsigned SHW   = $clog2(XLEN);
  localparam int unsigned PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OBUF_DEPTH + 1);
  localparam int unsigned NREG  = (STAGES > 1) ? STAGES - 1 : 1;

  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_SLL  = 2;
  localparam int unsigned OP_SLT  = 3;
  localparam int unsigned OP_SLTU = 4;
  localparam int unsigned OP_XOR  = 5;
  localparam int unsigned OP_SRL  = 6;
  localparam int unsigned OP_SRA  = 7;
  localparam int unsigned OP_OR   = 8;
  localparam int unsigned OP_AND  = 9;
  localparam int unsigned OP_EQ   = 10;
  localparam int unsigned OP_NE   = 11;
  localparam int unsigned OP_GE   = 12;
  localparam int unsigned OP_GEU  = 13;

  // Result of one ALU operation; unused encodings return zero.
  function automatic logic [XLEN-1:0] alu_calc(input logic [OP_W-1:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    sh       = b[SHW-1:0];
    alu_calc = '0;
    case (op)
      OP_W'(OP_ADD):  alu_calc = a + b;
      OP_W'(OP_SUB):  alu_calc = a - b;
      OP_W'(OP_SLL):  alu_calc = a << sh;
      OP_W'(OP_SLT):  alu_calc = XLEN'($signed(a) < $signed(b));
      OP_W'(OP_SLTU): alu_calc = XLEN'(a < b);
      OP_W'(OP_XOR):  alu_calc = a ^ b;
      OP_W'(OP_SRL):  alu_calc = a >> sh;
      OP_W'(OP_SRA):  alu_calc = XLEN'($signed(a) >>> sh);
      OP_W'(OP_OR):   alu_calc = a | b;
      OP_W'(OP_AND):  alu_calc = a & b;
      OP_W'(OP_EQ):   alu_calc = XLEN'(a == b);
      OP_W'(OP_NE):   alu_calc = XLEN'(a != b);
      OP_W'(OP_GE):   alu_calc = XLEN'($signed(a) >= $signed(b));
      OP_W'(OP_GEU):  alu_calc = XLEN'(a >= b);
      default:        alu_calc = '0;
    endcase
  endfunction

  // Circular increment that also works for non power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(OBUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic             accept;
  logic             pop;
  logic             wr_en;
  logic             last_valid;
  logic [OP_W-1:0]  last_op;
  logic [ROB_W-1:0] last_id;
  logic [XLEN-1:0]  last_v1;
  logic [XLEN-1:0]  last_v2;
  logic [XLEN-1:0]  result;

  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] occ_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_nxt;
  logic [ROB_W-1:0] head_id_nxt;
  logic [XLEN-1:0]  head_val_nxt;

  logic [ROB_W-1:0] obuf_id  [OBUF_DEPTH];
  logic [XLEN-1:0]  obuf_val [OBUF_DEPTH];

  assign accept = _alu_ready & ~_alu_full & rdy_in & ~_clear;
  assign pop    = _cdb_ready & _cdb_grant & rdy_in & ~_clear;

  generate
    if (STAGES > 1) begin : g_pipe
      logic [NREG-1:0]  s_valid;
      logic [OP_W-1:0]  s_op [NREG];
      logic [ROB_W-1:0] s_id [NREG];
      logic [XLEN-1:0]  s_v1 [NREG];
      logic [XLEN-1:0]  s_v2 [NREG];

      // Operand register chain; advances only when the core is ready.
      always_ff @(posedge clk_in) begin
        if (rst_in || _clear) begin
          s_valid <= '0;
        end else if (rdy_in) begin
          s_valid[0] <= accept;
          s_op[0]    <= _alu_op;
          s_id[0]    <= _alu_rob_id;
          s_v1[0]    <= _alu_v1;
          s_v2[0]    <= _alu_v2;
          for (int i = 1; i < int'(NREG); i++) begin
            s_valid[i] <= s_valid[i-1];
            s_op[i]    <= s_op[i-1];
            s_id[i]    <= s_id[i-1];
            s_v1[i]    <= s_v1[i-1];
            s_v2[i]    <= s_v2[i-1];
          end
        end
      end

      assign last_valid = s_valid[NREG-1];
      assign last_op    = s_op[NREG-1];
      assign last_id    = s_id[NREG-1];
      assign last_v1    = s_v1[NREG-1];
      assign last_v2    = s_v2[NREG-1];
    end else begin : g_direct
      assign last_valid = accept;
      assign last_op    = _alu_op;
      assign last_id    = _alu_rob_id;
      assign last_v1    = _alu_v1;
      assign last_v2    = _alu_v2;
    end
  endgenerate

  assign result = alu_calc(last_op, last_v1, last_v2);
  assign wr_en  = last_valid & rdy_in & ~_clear;

  // Next occupancy, FIFO pointers and the head entry to present next cycle.
  always_comb begin
    occ_nxt      = occ;
    cnt_nxt      = cnt;
    rd_nxt       = rd_ptr;
    wr_nxt       = wr_ptr;
    head_id_nxt  = '0;
    head_val_nxt = '0;

    if (accept && !pop) begin
      occ_nxt = occ + CNT_W'(1);
    end else if (!accept && pop) begin
      occ_nxt = occ - CNT_W'(1);
    end

    if (wr_en && !pop) begin
      cnt_nxt = cnt + CNT_W'(1);
    end else if (!wr_en && pop) begin
      cnt_nxt = cnt - CNT_W'(1);
    end

    if (pop) begin
      rd_nxt = ptr_inc(rd_ptr);
    end
    if (wr_en) begin
      wr_nxt = ptr_inc(wr_ptr);
    end

    // A write into an otherwise empty FIFO bypasses straight to the head.
    if (cnt_nxt != '0) begin
      if (wr_en && (wr_ptr == rd_nxt)) begin
        head_id_nxt  = last_id;
        head_val_nxt = result;
      end else begin
        head_id_nxt  = obuf_id[rd_nxt];
        head_val_nxt = obuf_val[rd_nxt];
      end
    end
  end

  // Control state and registered outputs; reset and flush both empty everything.
  always_ff @(posedge clk_in) begin
    if (rst_in || _clear) begin
      occ         <= '0;
      cnt         <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      _alu_full   <= 1'b0;
      _cdb_ready  <= 1'b0;
      _cdb_rob_id <= '0;
      _cdb_value  <= '0;
    end else if (rdy_in) begin
      occ         <= occ_nxt;
      cnt         <= cnt_nxt;
      rd_ptr      <= rd_nxt;
      wr_ptr      <= wr_nxt;
      _alu_full   <= (occ_nxt == CNT_W'(OBUF_DEPTH));
      _cdb_ready  <= (cnt_nxt != '0);
      _cdb_rob_id <= head_id_nxt;
      _cdb_value  <= head_val_nxt;
    end
  end

  // Result storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_in) begin
    if (wr_en && !rst_in) begin
      obuf_id[wr_ptr]  <= last_id;
      obuf_val[wr_ptr] <= result;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: reset, per-op latency/results, backpressure,
// flush, freeze and reset-over-freeze, with hand-computed expectations.
module tb_alu_pipe;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        alu_ready;
  logic [4:0]  alu_rob_id;
  logic [3:0]  alu_op;
  logic [31:0] alu_v1;
  logic [31:0] alu_v2;
  logic        alu_full;
  logic        cdb_grant;
  logic        cdb_ready;
  logic [4:0]  cdb_rob_id;
  logic [31:0] cdb_value;

  int n_assert = 0;
  int n_fail   = 0;

  alu_pipe dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    ._clear      (clear),
    ._alu_ready  (alu_ready),
    ._alu_rob_id (alu_rob_id),
    ._alu_op     (alu_op),
    ._alu_v1     (alu_v1),
    ._alu_v2     (alu_v2),
    ._alu_full   (alu_full),
    ._cdb_grant  (cdb_grant),
    ._cdb_ready  (cdb_ready),
    ._cdb_rob_id (cdb_rob_id),
    ._cdb_value  (cdb_value)
  );

  always #5 clk_in = ~clk_in;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] id,
                       input logic [31:0] a, input logic [31:0] b);
    alu_ready  = 1'b1;
    alu_op     = op;
    alu_rob_id = id;
    alu_v1     = a;
    alu_v2     = b;
  endtask

  // Issue one op with grant held high; result due two cycles later, then popped.
  task automatic vec(input string tag, input logic [3:0] op, input logic [4:0] id,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    drive(op, id, a, b);
    step();
    alu_ready = 1'b0;
    chk({tag, "_early"}, 32'(cdb_ready), 32'd0);
    step();
    chk({tag, "_rdy"}, 32'(cdb_ready), 32'd1);
    chk({tag, "_id"},  32'(cdb_rob_id), 32'(id));
    chk({tag, "_val"}, cdb_value, exp);
    step();
    chk({tag, "_popped"}, 32'(cdb_ready), 32'd0);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; alu_ready = 1'b0;
    alu_rob_id = '0; alu_op = '0; alu_v1 = '0; alu_v2 = '0; cdb_grant = 1'b0;

    // Reset
    step(); step();
    rst_in = 1'b0;
    chk("rst_full",  32'(alu_full), 32'd0);
    chk("rst_ready", 32'(cdb_ready), 32'd0);
    chk("rst_id",    32'(cdb_rob_id), 32'd0);
    chk("rst_value", cdb_value, 32'd0);

    // Latency and opcode results
    cdb_grant = 1'b1;
    vec("add",  4'd0,  5'd3,  32'd5,          32'd7,          32'd12);
    vec("sub",  4'd1,  5'd4,  32'd0,          32'd1,          32'hFFFF_FFFF);
    vec("sra",  4'd7,  5'd5,  32'h8000_0000,  32'd4,          32'hF800_0000);
    vec("sltu", 4'd4,  5'd6,  32'd1,          32'hFFFF_FFFF,  32'd1);
    vec("ge",   4'd12, 5'd7,  32'hFFFF_FFFF,  32'd1,          32'd0);
    vec("sll",  4'd2,  5'd8,  32'd1,          32'h21,         32'd2);
    vec("slt",  4'd3,  5'd9,  32'hFFFF_FFFF,  32'd1,          32'd1);
    vec("srl",  4'd6,  5'd10, 32'h8000_0000,  32'd4,          32'h0800_0000);
    vec("xor",  4'd5,  5'd11, 32'hF0F0_1234,  32'h0FF0_1200,  32'hFF00_0034);
    vec("or",   4'd8,  5'd12, 32'h0000_F000,  32'h0000_000F,  32'h0000_F00F);
    vec("and",  4'd9,  5'd13, 32'h0000_FF0F,  32'h0000_0FF0,  32'h0000_0F00);
    vec("eq",   4'd10, 5'd14, 32'd5,          32'd5,          32'd1);
    vec("ne",   4'd11, 5'd15, 32'd5,          32'd5,          32'd0);
    vec("geu",  4'd13, 5'd16, 32'd1,          32'hFFFF_FFFF,  32'd0);
    vec("op14", 4'd14, 5'd17, 32'd5,          32'd7,          32'd0);

    // Backpressure: fill to full, extra issue ignored, in-order drain
    cdb_grant = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(4'd0, 5'(i), 32'(i), 32'd0);
      step();
      chk($sformatf("bp_full_%0d", i), 32'(alu_full), 32'(i == 4));
    end
    drive(4'd0, 5'd5, 32'd5, 32'd0);
    step();
    alu_ready = 1'b0;
    chk("bp_full_hold", 32'(alu_full), 32'd1);
    chk("bp_head_rdy",  32'(cdb_ready), 32'd1);
    chk("bp_head_id",   32'(cdb_rob_id), 32'd1);
    chk("bp_head_val",  cdb_value, 32'd1);
    cdb_grant = 1'b1;
    step();
    chk("bp_full_fall", 32'(alu_full), 32'd0);
    chk("bp_pop2", 32'(cdb_rob_id), 32'd2);
    step();
    chk("bp_pop3", 32'(cdb_rob_id), 32'd3);
    step();
    chk("bp_pop4", 32'(cdb_rob_id), 32'd4);
    chk("bp_val4", cdb_value, 32'd4);
    step();
    chk("bp_empty", 32'(cdb_ready), 32'd0);
    step();
    chk("bp_no5", 32'(cdb_ready), 32'd0);

    // Flush with three ops outstanding and a simultaneous issue
    cdb_grant = 1'b0;
    for (int i = 6; i <= 8; i++) begin
      drive(4'd0, 5'(i), 32'(i), 32'd0);
      step();
    end
    clear = 1'b1; cdb_grant = 1'b1;
    drive(4'd0, 5'd9, 32'd9, 32'd0);
    step();
    clear = 1'b0; alu_ready = 1'b0;
    chk("clr_ready", 32'(cdb_ready), 32'd0);
    chk("clr_full",  32'(alu_full), 32'd0);
    chk("clr_id",    32'(cdb_rob_id), 32'd0);
    chk("clr_value", cdb_value, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("clr_quiet_%0d", i), 32'(cdb_ready), 32'd0);
    end
    cdb_grant = 1'b0;
    for (int i = 10; i <= 13; i++) begin
      drive(4'd0, 5'(i), 32'(i), 32'd0);
      step();
      chk($sformatf("clr_occ_%0d", i), 32'(alu_full), 32'(i == 13));
    end
    alu_ready = 1'b0;
    chk("clr_head10", 32'(cdb_rob_id), 32'd10);
    cdb_grant = 1'b1;
    for (int i = 11; i <= 13; i++) begin
      step();
      chk($sformatf("clr_pop_%0d", i), 32'(cdb_rob_id), 32'(i));
    end
    step();
    chk("clr_drained", 32'(cdb_ready), 32'd0);

    // Simultaneous accept and pop keep occupancy unchanged
    cdb_grant = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(4'd0, 5'(i), 32'(i), 32'd0);
      step();
    end
    alu_ready = 1'b0;
    step(); step();
    cdb_grant = 1'b1;
    drive(4'd0, 5'd4, 32'd4, 32'd0);
    step();
    cdb_grant = 1'b0;
    chk("same_full3", 32'(alu_full), 32'd0);
    chk("same_head2", 32'(cdb_rob_id), 32'd2);
    drive(4'd0, 5'd5, 32'd5, 32'd0);
    step();
    alu_ready = 1'b0;
    chk("same_full4", 32'(alu_full), 32'd1);
    cdb_grant = 1'b1;
    for (int i = 3; i <= 5; i++) begin
      step();
      chk($sformatf("same_pop_%0d", i), 32'(cdb_rob_id), 32'(i));
    end
    step();
    chk("same_drained", 32'(cdb_ready), 32'd0);

    // Freeze while the op is in flight delays the result by three cycles
    drive(4'd0, 5'd20, 32'd100, 32'd23);
    step();
    alu_ready = 1'b0; rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("frz_wait_%0d", i), 32'(cdb_ready), 32'd0);
    end
    rdy_in = 1'b1;
    step();
    chk("frz_rdy", 32'(cdb_ready), 32'd1);
    chk("frz_id",  32'(cdb_rob_id), 32'd20);
    chk("frz_val", cdb_value, 32'd123);
    step();
    chk("frz_popped", 32'(cdb_ready), 32'd0);

    // Freeze while a result is presented: stable, no pop, no accept
    cdb_grant = 1'b0;
    drive(4'd1, 5'd21, 32'd10, 32'd3);
    step();
    alu_ready = 1'b0;
    step();
    chk("frz2_rdy", 32'(cdb_ready), 32'd1);
    rdy_in = 1'b0; cdb_grant = 1'b1;
    drive(4'd0, 5'd22, 32'd1, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("frz2_rdy_%0d", i), 32'(cdb_ready), 32'd1);
      chk($sformatf("frz2_id_%0d", i),  32'(cdb_rob_id), 32'd21);
      chk($sformatf("frz2_val_%0d", i), cdb_value, 32'd7);
    end
    rdy_in = 1'b1; alu_ready = 1'b0;
    step();
    chk("frz2_popped", 32'(cdb_ready), 32'd0);
    step(); step();
    chk("frz2_no22", 32'(cdb_ready), 32'd0);

    // Reset wins even while frozen
    cdb_grant = 1'b0;
    drive(4'd0, 5'd23, 32'd1, 32'd2);
    step();
    alu_ready = 1'b0;
    step();
    chk("rst2_pre", 32'(cdb_ready), 32'd1);
    rdy_in = 1'b0; rst_in = 1'b1;
    step();
    rst_in = 1'b0; rdy_in = 1'b1;
    chk("rst2_ready", 32'(cdb_ready), 32'd0);
    chk("rst2_id",    32'(cdb_rob_id), 32'd0);
    chk("rst2_full",  32'(alu_full), 32'd0);
    step(); step();
    chk("rst2_quiet", 32'(cdb_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
